// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   - uart_rx_state_t   : receive FSM state encoding
//   - UART_DATA_BITS    : default data bits per frame
//   - UART_SAMPLE_RATE  : default SampleTick pulses per bit period
//   - uart_parity_error : parity check helper (data zero-extended to 9 bits)
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS     = 32'd8;
    localparam int UART_SAMPLE_RATE   = 32'd16;
    localparam int UART_MAX_DATA_BITS = 32'd9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    // Zero padding of narrow words leaves the XOR reduction unchanged, so one
    // fixed-width helper serves every frame width.
    function automatic logic uart_parity_error(
        input logic [UART_MAX_DATA_BITS-1:0] data,
        input logic                          parity_bit,
        input logic                          odd
    );
        return (((^data) ^ parity_bit) != odd);
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// -----------------------------------------------------------------------------
// uart_rx_controller_if
// Consumer-side bus of the UART receiver: holding register, status flags and
// the Valid/Ready handshake.
//   Data         : received word
//   Valid        : Data holds an unconsumed word
//   Ready        : consumer accepts (transfer on Valid & Ready)
//   FramingError : stop bit sampled low, travels with Data
//   ParityError  : parity mismatch, travels with Data
//   Overrun      : one-cycle pulse, completed frame dropped
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_controller_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
) ();

    logic [DATA_BITS-1:0] Data;
    logic                 Valid;
    logic                 Ready;
    logic                 FramingError;
    logic                 ParityError;
    logic                 Overrun;

    modport master (
        output Data,
        output Valid,
        output FramingError,
        output ParityError,
        output Overrun,
        input  Ready
    );

    modport slave (
        input  Data,
        input  Valid,
        input  FramingError,
        input  ParityError,
        input  Overrun,
        output Ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to RESET_VALUE so an idle-high serial line does not look like a start
// bit straight out of reset.
// Ports:
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: first stage captures the pin, second stage the first stage.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_controller
// Oversampling UART receiver. Detects the start edge on the synchronized Rx
// line, samples every bit at mid-bit using SampleTick (SAMPLE_RATE ticks per
// bit), deframes LSB-first data and hands complete words to the consumer
// through a Valid/Ready holding register.
// Ports:
//   Clock      : system clock, rising edge
//   ClearN     : asynchronous active-low reset
//   Enable     : receiver enable; low forces IDLE and clears counters
//   SampleTick : one-cycle strobe at BAUD*SAMPLE_RATE
//   Rx         : asynchronous serial input, idle high
//   Busy       : FSM not in IDLE
//   bus        : consumer bus (Data/Valid/Ready/FramingError/ParityError/Overrun)
// Build option:
//   UART_RX_PARITY_EN : adds a parity bit between data and stop bit and the
//                       PARITY_ODD parameter; without it ParityError is 0.
// -----------------------------------------------------------------------------
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SAMPLE_RATE = UART_SAMPLE_RATE
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD  = 32'd0
`endif
) (
    input  logic                 Clock,
    input  logic                 ClearN,
    input  logic                 Enable,
    input  logic                 SampleTick,
    input  logic                 Rx,
    output logic                 Busy,
    uart_rx_controller_if.master bus
);

    localparam int TICK_W = $clog2(SAMPLE_RATE);
    localparam int BIT_W  = (DATA_BITS > 32'd1) ? $clog2(DATA_BITS) : 32'd1;

    localparam logic [TICK_W-1:0] TICK_ZERO      = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(32'd1);
    localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(SAMPLE_RATE / 32'd2 - 32'd1);
    localparam logic [TICK_W-1:0] TICK_FULL_LAST = TICK_W'(SAMPLE_RATE - 32'd1);
    localparam logic [BIT_W-1:0]  BIT_ZERO       = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE        = BIT_W'(32'd1);
    localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_BITS - 32'd1);

    logic                 rx_s;
    logic [TICK_W-1:0]    tick_last_s;
    logic                 sample_s;
    logic                 frame_done_s;
    logic                 stop_bit_s;

    uart_rx_state_t       state_q;
    uart_rx_state_t       state_d;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [TICK_W-1:0]    tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;

    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 framing_err_q;
    logic                 framing_err_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 busy_q;
    logic                 busy_d;

`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q;
    logic                 parity_bit_d;
    logic                 parity_err_q;
    logic                 parity_err_d;
`endif

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (Clock),
        .rst_n (ClearN),
        .d     (Rx),
        .q     (rx_s)
    );

    // Sampling point: last tick of the half-bit (START) or full-bit interval.
    always_comb begin
        if (state_q == START) begin
            tick_last_s = TICK_HALF_LAST;
        end else begin
            tick_last_s = TICK_FULL_LAST;
        end
        sample_s = SampleTick && (tick_cnt_q == tick_last_s);
    end

    // Tick counter: restarts at every sample point and is held at 0 while idle,
    // so it never relies on overflow to realign.
    always_comb begin
        if (!Enable || (state_q == IDLE) || sample_s) begin
            tick_cnt_d = TICK_ZERO;
        end else if (SampleTick) begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Framing FSM: next state, bit counter and shift register.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_s = 1'b0;
        stop_bit_s   = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif
        if (!Enable) begin
            state_d   = IDLE;
            bit_cnt_d = BIT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = BIT_ZERO;
                    if (!rx_s) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (sample_s) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = START;
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        shift_d[bit_cnt_q] = rx_s;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                            state_d   = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_s) begin
                        parity_bit_d = rx_s;
                        state_d      = STOP;
                    end else begin
                        state_d = PARITY;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid stop bit lets the next start edge be seen
                    // during the second half of this stop bit.
                    if (sample_s) begin
                        frame_done_s = 1'b1;
                        stop_bit_s   = rx_s;
                        state_d      = IDLE;
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = BIT_ZERO;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Holding register: load a finished frame unless an unconsumed word would
    // be overwritten, in which case the new frame is dropped and flagged.
    always_comb begin
        data_d        = data_q;
        valid_d       = valid_q;
        framing_err_d = framing_err_q;
        overrun_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = parity_err_q;
`endif
        if (frame_done_s) begin
            if (!valid_q || bus.Ready) begin
                data_d        = shift_q;
                valid_d       = 1'b1;
                framing_err_d = !stop_bit_s;
`ifdef UART_RX_PARITY_EN
                parity_err_d  = uart_parity_error(UART_MAX_DATA_BITS'(shift_q),
                                                  parity_bit_q, (PARITY_ODD != 32'd0));
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.Ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // FSM, counter and shift register flops.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            state_q      <= IDLE;
            tick_cnt_q   <= TICK_ZERO;
            bit_cnt_q    <= BIT_ZERO;
            shift_q      <= {DATA_BITS{1'b0}};
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
`endif
        end
    end

    // Holding register and status flag flops.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            data_q        <= {DATA_BITS{1'b0}};
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            data_q        <= data_d;
            valid_q       <= valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign bus.Data         = data_q;
    assign bus.Valid        = valid_q;
    assign bus.FramingError = framing_err_q;
    assign bus.Overrun      = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.ParityError  = parity_err_q;
`else
    assign bus.ParityError  = 1'b0;
`endif
    assign Busy             = busy_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_controller
// Directed bench for uart_rx_controller with DATA_BITS=8, SAMPLE_RATE=16 and a
// SampleTick every 4 clocks (64 clocks per bit). Parity cases run only when
// UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_controller;

    localparam int BIT_CLKS = 32'd64;

    logic clk;
    logic clear_n;
    logic enable;
    logic sample_tick;
    logic rx;
    logic busy;
    logic seen;
`ifdef UART_RX_PARITY_EN
    logic tx_par;
`endif

    int n_vec;
    int n_miss;

    uart_rx_controller_if #(.DATA_BITS(32'd8)) bus_if ();

    uart_rx_controller dut (
        .Clock      (clk),
        .ClearN     (clear_n),
        .Enable     (enable),
        .SampleTick (sample_tick),
        .Rx         (rx),
        .Busy       (busy),
        .bus        (bus_if)
    );

    // System clock, 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SampleTick strobe: one cycle high every fourth cycle.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit followed by the nbits least significant data bits.
    task automatic send_head(input logic [7:0] byte_v, input int nbits);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = byte_v[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    // Full frame up to the start of the stop bit; the stop level is left on rx.
    task automatic send_frame(input logic [7:0] byte_v, input logic stop_v);
        send_head(byte_v, 8);
`ifdef UART_RX_PARITY_EN
        rx = tx_par;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop_v;
    endtask

    task automatic wait_valid(output logic hit);
        hit = 1'b0;
        for (int i = 0; (i < 128) && !hit; i++) begin
            @(negedge clk);
            if (bus_if.Valid) hit = 1'b1;
        end
    endtask

    task automatic wait_overrun(output logic hit);
        hit = 1'b0;
        for (int i = 0; (i < 128) && !hit; i++) begin
            @(negedge clk);
            if (bus_if.Overrun) hit = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"},    32'(bus_if.Data),         32'h0);
        check_eq({tag, "_valid"},   32'(bus_if.Valid),        32'h0);
        check_eq({tag, "_fe"},      32'(bus_if.FramingError), 32'h0);
        check_eq({tag, "_pe"},      32'(bus_if.ParityError),  32'h0);
        check_eq({tag, "_overrun"}, 32'(bus_if.Overrun),      32'h0);
        check_eq({tag, "_busy"},    32'(busy),                32'h0);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        clear_n      = 1'b0;
        enable       = 1'b1;
        rx           = 1'b1;
        bus_if.Ready = 1'b1;
`ifdef UART_RX_PARITY_EN
        tx_par       = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check_idle_outputs("rst");
        clear_n = 1'b1;
        repeat (8) @(negedge clk);

        // 1: clean frame, consumer ready -> single-cycle Valid.
        send_frame(8'hA5, 1'b1);
        wait_valid(seen);
        check_eq("t1_valid_seen", 32'(seen),                32'h1);
        check_eq("t1_data",       32'(bus_if.Data),         32'hA5);
        check_eq("t1_fe",         32'(bus_if.FramingError), 32'h0);
        check_eq("t1_overrun",    32'(bus_if.Overrun),      32'h0);
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(bus_if.Valid),        32'h0);
        repeat (BIT_CLKS) @(negedge clk);
        check_eq("t1_busy_idle",  32'(busy),                32'h0);

        // 2: false start, low for 4 ticks only.
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("t2_busy_start", 32'(busy), 32'h1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check_eq("t2_busy_drop",  32'(busy),         32'h0);
        check_eq("t2_valid",      32'(bus_if.Valid), 32'h0);

        // 3: stop bit low -> word still delivered with FramingError.
        send_frame(8'h3C, 1'b0);
        wait_valid(seen);
        check_eq("t3_valid_seen", 32'(seen),                32'h1);
        check_eq("t3_data",       32'(bus_if.Data),         32'h3C);
        check_eq("t3_fe",         32'(bus_if.FramingError), 32'h1);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq("t3_busy_idle",  32'(busy),                32'h0);

        // 4: back-to-back frames with the consumer stalled -> overrun.
        bus_if.Ready = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_valid(seen);
        check_eq("t4_valid_seen", 32'(seen),        32'h1);
        check_eq("t4_data1",      32'(bus_if.Data), 32'h11);
        repeat (40) @(negedge clk);
        send_frame(8'h22, 1'b1);
        wait_overrun(seen);
        check_eq("t4_overrun_seen", 32'(seen),         32'h1);
        check_eq("t4_data_held",    32'(bus_if.Data),  32'h11);
        check_eq("t4_valid_held",   32'(bus_if.Valid), 32'h1);
        @(negedge clk);
        check_eq("t4_overrun_pulse", 32'(bus_if.Overrun), 32'h0);
        bus_if.Ready = 1'b1;
        @(negedge clk);
        check_eq("t4_valid_drop",  32'(bus_if.Valid), 32'h0);
        check_eq("t4_data_retain", 32'(bus_if.Data),  32'h11);
        repeat (BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 5: even parity; 0x07 has three ones so the parity bit must be 1.
        tx_par = 1'b0;
        send_frame(8'h07, 1'b1);
        wait_valid(seen);
        check_eq("t5_pe_bad",  32'(bus_if.ParityError), 32'h1);
        repeat (BIT_CLKS) @(negedge clk);
        tx_par = 1'b1;
        send_frame(8'h07, 1'b1);
        wait_valid(seen);
        check_eq("t5_pe_good", 32'(bus_if.ParityError), 32'h0);
        check_eq("t5_data",    32'(bus_if.Data),        32'h07);
        repeat (BIT_CLKS) @(negedge clk);
        tx_par = 1'b0;
`endif

        // 6a: Enable low mid-frame keeps the held word.
        bus_if.Ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        wait_valid(seen);
        check_eq("t6_valid_seen", 32'(seen),        32'h1);
        check_eq("t6_data",       32'(bus_if.Data), 32'h5A);
        repeat (BIT_CLKS) @(negedge clk);
        send_head(8'h99, 3);
        check_eq("t6_busy_mid",   32'(busy), 32'h1);
        enable = 1'b0;
        rx     = 1'b1;
        @(negedge clk);
        check_eq("t6_busy_off",   32'(busy),         32'h0);
        check_eq("t6_valid_kept", 32'(bus_if.Valid), 32'h1);
        check_eq("t6_data_kept",  32'(bus_if.Data),  32'h5A);
        repeat (BIT_CLKS) @(negedge clk);
        enable = 1'b1;
        repeat (8) @(negedge clk);

        // 6b: ClearN mid-frame clears everything without waiting for a clock edge.
        send_head(8'h66, 2);
        check_eq("t6_busy_mid2", 32'(busy), 32'h1);
        #2 clear_n = 1'b0;
        #1 check_idle_outputs("t6_clr");
        @(negedge clk);
        rx      = 1'b1;
        clear_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
